// File: rtl/vs_rr_arbiter_4x1.sv
// Purpose: four-way round-robin arbiter driving the select of a 4:1 mux; holds each grant until release.
// Latency: a request seen at one edge is granted by that edge; back-to-back handover on release, no idle cycle.
// Backpressure: a grant ends on done, on its request dropping, or when the hold limit is reached.
module vs_rr_arbiter_4x1 #(
    parameter int         HOLD_MAX    = 16,
    parameter logic [1:0] DEFAULT_SEL = 2'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       grant_valid
);

    localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       select_q, select_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] scan_base;
    logic [2:0] pick;
    logic       hold_hit;
    logic       release_now;

    // Returns {found, index} of the first set request scanning base, base+1, ... mod 4.
    function automatic logic [2:0] arb(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // On release the holder becomes lowest priority by scanning from the slot after it.
    assign scan_base   = (state_q == GRANT) ? (select_q + 2'd1) : ptr_q;
    assign pick        = arb(req, scan_base);
    assign hold_hit    = (HOLD_MAX != 0) && (cnt_q == CNT_LAST);
    assign release_now = done | ~req[select_q] | hold_hit;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick[2]) begin
                    state_d  = GRANT;
                    grant_d  = 4'b0001 << pick[1:0];
                    select_d = pick[1:0];
                    cnt_d    = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = select_q + 2'd1;
                    cnt_d = '0;
                    if (pick[2]) begin
                        grant_d  = 4'b0001 << pick[1:0];
                        select_d = pick[1:0];
                    end else begin
                        // select keeps the last index so the mux output stays quiet while idle
                        state_d = IDLE;
                        grant_d = 4'b0000;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= 4'b0000;
            select_q <= DEFAULT_SEL;
            ptr_q    <= 2'd0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign select      = select_q;
    assign grant_valid = (state_q == GRANT);

endmodule

// File: tb/tb_vs_rr_arbiter_4x1.sv
// Bench for vs_rr_arbiter_4x1: directed scenarios plus random traffic against a queue-free
// behavioural model that tracks who holds the mux, for how many cycles, and where the scan resumes.
module tb_vs_rr_arbiter_4x1;

    localparam int         HOLD = 4;
    localparam logic [1:0] DSEL = 2'd0;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] select;
    logic       grant_valid;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit         m_vld;
    int         m_g;
    logic [1:0] m_sel;
    int         m_ptr;
    int         m_held;

    vs_rr_arbiter_4x1 #(.HOLD_MAX(HOLD), .DEFAULT_SEL(DSEL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .select     (select),
        .grant_valid(grant_valid)
    );

    always #5 clk = ~clk;

    function automatic int m_arb(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_vld  = 1'b0;
        m_g    = 0;
        m_sel  = DSEL;
        m_ptr  = 0;
        m_held = 0;
    endtask

    task automatic m_edge(input logic [3:0] r, input logic d);
        int n;
        if (!m_vld) begin
            n = m_arb(r, m_ptr);
            if (n >= 0) begin
                m_vld = 1'b1; m_g = n; m_sel = 2'(n); m_held = 1;
            end
        end else if (d || !r[m_g] || m_held == HOLD) begin
            m_ptr = (m_g + 1) % 4;
            n = m_arb(r, m_ptr);
            if (n >= 0) begin
                m_g = n; m_sel = 2'(n); m_held = 1;
            end else begin
                m_vld = 1'b0;
            end
        end else begin
            m_held++;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic ev);
        n_vec++;
        assert ({grant, select, grant_valid} === {eg, es, ev}) else begin
            n_err++;
            $error("FAIL %s: got grant=%b select=%0d valid=%b, want grant=%b select=%0d valid=%b",
                   tag, grant, select, grant_valid, eg, es, ev);
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eg;
        eg = m_vld ? (4'b0001 << m_g) : 4'b0000;
        check(tag, eg, m_sel, m_vld);
    endtask

    task automatic step(input logic [3:0] r, input logic d, input string tag);
        req  = r;
        done = d;
        @(posedge clk);
        m_edge(r, d);
        #1;
        check_model(tag);
    endtask

    // Pulses reset between edges; called at edge+1.
    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        m_reset();
        #1 check_model("async_reset");
        #1 reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        logic       d;
        logic [3:0] exp_g;

        reset_n = 1'b0;
        req     = 4'b0000;
        done    = 1'b0;
        m_reset();
        #2 check("reset_no_clock", 4'b0000, DSEL, 1'b0);
        #10 reset_n = 1'b1;

        // single request, then release by done with request dropping
        step(4'b0100, 1'b0, "single_grant");
        check("single_grant_const", 4'b0100, 2'd2, 1'b1);
        step(4'b0000, 1'b1, "single_release");
        check("idle_keeps_select", 4'b0000, 2'd2, 1'b0);

        // rotation with done every granted cycle
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b1, "rotate");
            exp_g = 4'b0001 << (i % 4);
            check("rotate_const", exp_g, 2'(i % 4), 1'b1);
        end

        // hold limit forces handover every HOLD cycles
        pulse_reset();
        for (int i = 0; i < 12; i++) begin
            step(4'b0011, 1'b0, "hold_limit");
            exp_g = ((i / HOLD) % 2 == 0) ? 4'b0001 : 4'b0010;
            check("hold_limit_const", exp_g, 2'((i / HOLD) % 2), 1'b1);
        end

        // request drop moves the grant at the next edge
        pulse_reset();
        step(4'b0011, 1'b0, "drop_setup");
        step(4'b0010, 1'b0, "req_drop");
        check("req_drop_const", 4'b0010, 2'd1, 1'b1);

        // asynchronous reset mid-grant, then pointer restarts at 0
        pulse_reset();
        step(4'b1000, 1'b0, "grant3");
        check("grant3_const", 4'b1000, 2'd3, 1'b1);
        #2 reset_n = 1'b0;
        m_reset();
        #1 check("mid_grant_reset", 4'b0000, DSEL, 1'b0);
        #1 reset_n = 1'b1;
        step(4'b1111, 1'b0, "post_reset");
        check("post_reset_const", 4'b0001, 2'd0, 1'b1);

        // random traffic: requests tend to persist so grants run long enough to hit the limit
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 99) == 0) pulse_reset();
            step(r, d, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
